// File: rtl/slave_arbiter_if.sv
// Request/grant bundle between the two crossbar masters and one slave arbiter.
// The "slave" modport is the arbiter's view; the "master" modport is the
// surrounding fabric (master request sources plus the slave's ack).
interface slave_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              master_0_req;
  logic [ADDR_W-1:0] master_0_addr;
  logic              master_0_cmd;
  logic [31:0]       master_0_wdata;
  logic              master_1_req;
  logic [ADDR_W-1:0] master_1_addr;
  logic              master_1_cmd;
  logic [31:0]       master_1_wdata;
  logic              slave_ack;
  logic              slave_req;
  logic [ADDR_W-1:0] slave_addr;
  logic              slave_cmd;
  logic [31:0]       slave_wdata;
  logic              master_0_granted;
  logic              master_1_granted;
  logic              timeout_err;

  modport slave (
    input  master_0_req, master_0_addr, master_0_cmd, master_0_wdata,
    input  master_1_req, master_1_addr, master_1_cmd, master_1_wdata,
    input  slave_ack,
    output slave_req, slave_addr, slave_cmd, slave_wdata,
    output master_0_granted, master_1_granted, timeout_err
  );

  modport master (
    output master_0_req, master_0_addr, master_0_cmd, master_0_wdata,
    output master_1_req, master_1_addr, master_1_cmd, master_1_wdata,
    output slave_ack,
    input  slave_req, slave_addr, slave_cmd, slave_wdata,
    input  master_0_granted, master_1_granted, timeout_err
  );
endinterface

// File: rtl/slave_arbiter.sv
// Per-slave request stage of a 2x2 crossbar: round-robin choice between the
// two masters, registered command forwarding to the slave, per-master grant
// flags and an ack timeout that aborts a stalled request.
module slave_arbiter #(
  parameter logic SLAVE_ID = 1'b0,
  parameter int   ADDR_W   = 32,
  parameter int   TIMEOUT  = 16
) (
  input logic            clk,
  input logic            rst,
  slave_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic              ptr;          // master that has priority on the next tie
  logic              winner;       // master currently owning the slave
  logic [CNT_W-1:0]  cnt;
  logic              slave_req_q;
  logic [ADDR_W-1:0] slave_addr_q;
  logic              slave_cmd_q;
  logic [31:0]       slave_wdata_q;
  logic              granted_0_q;
  logic              granted_1_q;
  logic              timeout_err_q;

  logic              hit_0;
  logic              hit_1;
  logic              pick;
  logic              other_hit;
  logic              load_sel;
  logic [ADDR_W-1:0] load_addr;
  logic              load_cmd;
  logic [31:0]       load_wdata;

  // Eligibility, round-robin winner and the source of the next command load.
  always_comb begin
    hit_0 = bus.master_0_req & (bus.master_0_addr[ADDR_W-1] == SLAVE_ID);
    hit_1 = bus.master_1_req & (bus.master_1_addr[ADDR_W-1] == SLAVE_ID);
    pick  = 1'b0;
    if (ptr) begin
      if (hit_1) pick = 1'b1;
      else       pick = 1'b0;
    end else begin
      if (hit_0) pick = 1'b0;
      else       pick = 1'b1;
    end
    other_hit = winner ? hit_0 : hit_1;
    // In IDLE we load the fresh winner; in BUSY only a handover loads, and
    // that always goes to the master that is not currently owning the slave.
    load_sel = (state == IDLE) ? pick : ~winner;
    if (load_sel) begin
      load_addr  = bus.master_1_addr;
      load_cmd   = bus.master_1_cmd;
      load_wdata = bus.master_1_wdata;
    end else begin
      load_addr  = bus.master_0_addr;
      load_cmd   = bus.master_0_cmd;
      load_wdata = bus.master_0_wdata;
    end
  end

  // Arbitration FSM with registered slave command, grants and timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      winner        <= 1'b0;
      cnt           <= '0;
      slave_req_q   <= 1'b0;
      slave_addr_q  <= '0;
      slave_cmd_q   <= 1'b0;
      slave_wdata_q <= 32'h0000_0000;
      granted_0_q   <= 1'b0;
      granted_1_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state)
        IDLE: begin
          // slave_ack is deliberately ignored here.
          if (hit_0 | hit_1) begin
            state         <= BUSY;
            winner        <= pick;
            cnt           <= '0;
            slave_req_q   <= 1'b1;
            slave_addr_q  <= load_addr;
            slave_cmd_q   <= load_cmd;
            slave_wdata_q <= load_wdata;
            granted_0_q   <= ~pick;
            granted_1_q   <= pick;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (bus.slave_ack) begin
            // Ack beats a coinciding timeout; priority rotates away from winner.
            ptr <= ~winner;
            cnt <= '0;
            if (other_hit) begin
              winner        <= ~winner;
              slave_addr_q  <= load_addr;
              slave_cmd_q   <= load_cmd;
              slave_wdata_q <= load_wdata;
              granted_0_q   <= winner;
              granted_1_q   <= ~winner;
            end else begin
              state       <= IDLE;
              slave_req_q <= 1'b0;
              granted_0_q <= 1'b0;
              granted_1_q <= 1'b0;
            end
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            ptr           <= ~winner;
            cnt           <= '0;
            timeout_err_q <= 1'b1;
            slave_req_q   <= 1'b0;
            granted_0_q   <= 1'b0;
            granted_1_q   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          slave_req_q <= 1'b0;
          granted_0_q <= 1'b0;
          granted_1_q <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

  assign bus.slave_req        = slave_req_q;
  assign bus.slave_addr       = slave_addr_q;
  assign bus.slave_cmd        = slave_cmd_q;
  assign bus.slave_wdata      = slave_wdata_q;
  assign bus.master_0_granted = granted_0_q;
  assign bus.master_1_granted = granted_1_q;
  assign bus.timeout_err      = timeout_err_q;

endmodule
